serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
- Parallel-in, serial-out transmitter: start bit, then WIDTH data bits LSB first, then stop bit.
- Idle line is high.
- Transmit end of the single-line link whose receive side captures bits with load-enabled flip-flops.
- Sits between switch/register parallel data and a board serial pin or an on-board receiver.

Parameters:
- WIDTH, 8, number of data bits per frame (1..16).
- CLK_DIV, 4, clk cycles per serial bit (>=1).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- clr_n  input  1  asynchronous active-low reset.
- ld  input  1  request to send; sampled high in IDLE captures din.
- din  input  WIDTH  parallel data; sampled only on the accepting edge.
- sout  output  1  serial line; 1 when idle.
- busy  output  1  high while a frame is in progress (START, DATA, STOP).
- done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (clr_n=0, asynchronous):
  - state=IDLE, sout=1, busy=0, done=0.
  - Shift register, bit counter and divider all 0.
  - Takes effect immediately, including mid-frame; the partial frame is abandoned.
  - After release, nothing is sent until a new ld.
- States: IDLE, START, DATA, STOP. All outputs registered.
- IDLE:
  - sout=1, busy=0.
  - ld=1 at an edge: shift register<=din, divider<=0, bit index<=0, go to START.
- START:
  - sout=0, busy=1, held for CLK_DIV cycles.
  - Then go to DATA.
- DATA:
  - sout=shift[0], held for CLK_DIV cycles per bit.
  - At the end of each bit: shift right by 1, bit index+1.
  - After bit WIDTH-1 completes, go to STOP.
- STOP:
  - sout=1, busy=1, held for CLK_DIV cycles.
  - Then go to IDLE with done=1 for exactly that first IDLE cycle.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps to 0 on every bit boundary.
  - With CLK_DIV=1, each bit lasts one cycle.
- Latency and frame length:
  - sout changes on the edge that accepts ld (no extra cycle).
  - Frame length is exactly (WIDTH+2)*CLK_DIV cycles of busy=1.
- ld while busy=1 is ignored. din changes during a frame do not affect the frame.
- Back-to-back: ld=1 in the done cycle (IDLE) is accepted. The next start bit begins on that edge, so there is exactly one idle-high cycle between frames.
- ld held high continuously produces frames separated by one idle cycle each.
- done never asserts for an aborted (reset) frame.

Test Plan:
- Reset mid-frame:
  - Stimulus: drop clr_n during DATA, between clock edges.
  - Required: sout=1, busy=0, done=0 immediately, with no clock edge needed.
  - After release with ld=0 for 20 cycles: sout stays 1.
- Single frame (WIDTH=8, CLK_DIV=4):
  - Stimulus: din=8'hA5, one-cycle ld.
  - Required sout, each level held 4 cycles: 0 | 1,0,1,0,0,1,0,1 | 1.
  - busy=1 for exactly 40 cycles; done=1 for one cycle on cycle 41; sout=1 afterward.
- Ignore while busy:
  - Stimulus: ld=1 with din=8'h00 at cycle 10 of an 8'hFF frame.
  - Required: serial data bits all 1, frame length unchanged at 40 cycles, no second frame.
- Back-to-back:
  - Stimulus: ld held high, din=8'h3C then 8'hC3.
  - Required: exactly one idle-high cycle, coincident with done, between the two frames.
  - Second frame bits: 1,1,0,0,0,0,1,1.
- CLK_DIV=1 boundary:
  - Stimulus: din=8'h01, one-cycle ld.
  - Required sout: 0,1,0,0,0,0,0,0,0,1 on consecutive cycles; busy 10 cycles; done on cycle 11.
- din stability:
  - Stimulus: toggle din every cycle after the accepting edge of 8'h5A.
  - Required: transmitted data bits 0,1,0,1,1,0,1,0.

Source files
------------

// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx
//  Purpose  : Parallel-in, serial-out frame transmitter. Each frame is one
//             low start bit, WIDTH data bits sent LSB first, and one high stop
//             bit. Every bit is held for CLK_DIV clock cycles. The line idles
//             high.
//  Ports    : clk   - system clock, rising-edge active
//             clr_n - asynchronous active-low clear; abandons any partial frame
//             ld    - send request; only honoured in IDLE
//             din   - parallel data; captured on the accepting edge only
//             sout  - serial line output (registered)
//             busy  - high during START, DATA and STOP (registered)
//             done  - one-cycle pulse in the first IDLE cycle after a frame
//  Revision : 1.0 - initial release
// ============================================================================
module serial_tx #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (WIDTH   > 1) ? $clog2(WIDTH)   : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] c_div_max  = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             r_state, w_state_n;
    logic [WIDTH-1:0]   r_shift, w_shift_n;
    logic [IDX_W-1:0]   r_idx,   w_idx_n;
    logic [DIV_W-1:0]   r_div,   w_div_n;
    logic               w_sout_n, w_busy_n, w_done_n;
    logic               w_bit_end;
    logic [WIDTH-1:0]   w_shifted;

    assign w_bit_end = (r_div == c_div_max);
    assign w_shifted = r_shift >> 1;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_div   <= '0;
            sout    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_shift <= w_shift_n;
            r_idx   <= w_idx_n;
            r_div   <= w_div_n;
            sout    <= w_sout_n;
            busy    <= w_busy_n;
            done    <= w_done_n;
        end
    end

    // Outputs are computed here as next-state values so that sout/busy/done
    // are flops; in particular the start bit appears on the very edge that
    // accepts ld.
    always_comb begin
        w_state_n = r_state;
        w_shift_n = r_shift;
        w_idx_n   = r_idx;
        w_div_n   = r_div;
        w_sout_n  = sout;
        w_busy_n  = busy;
        w_done_n  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_sout_n = 1'b1;
                w_busy_n = 1'b0;
                if (ld) begin
                    w_shift_n = din;
                    w_div_n   = '0;
                    w_idx_n   = '0;
                    w_state_n = S_START;
                    w_sout_n  = 1'b0;
                    w_busy_n  = 1'b1;
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_div_n   = '0;
                    w_state_n = S_DATA;
                    w_sout_n  = r_shift[0];
                end else begin
                    w_div_n = r_div + DIV_W'(1);
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    w_div_n   = '0;
                    w_shift_n = w_shifted;
                    w_idx_n   = r_idx + IDX_W'(1);
                    if (r_idx == c_last_idx) begin
                        w_state_n = S_STOP;
                        w_sout_n  = 1'b1;
                    end else begin
                        // Next bit is what becomes bit 0 after this shift.
                        w_sout_n = w_shifted[0];
                    end
                end else begin
                    w_div_n = r_div + DIV_W'(1);
                end
            end

            S_STOP: begin
                if (w_bit_end) begin
                    w_div_n   = '0;
                    w_state_n = S_IDLE;
                    w_sout_n  = 1'b1;
                    w_busy_n  = 1'b0;
                    w_done_n  = 1'b1;
                end else begin
                    w_div_n = r_div + DIV_W'(1);
                end
            end

            default: begin
                w_state_n = S_IDLE;
                w_sout_n  = 1'b1;
                w_busy_n  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_tx
//  Purpose  : Self-checking bench for serial_tx. Two instances share the clock
//             and clear: u_div4 (WIDTH=8, CLK_DIV=4) and u_div1 (WIDTH=8,
//             CLK_DIV=1). Expected line levels come from the frame definition:
//             cycle k after acceptance carries bit k/CLK_DIV of
//             {stop=1, data[7:0], start=0}.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_tx;

    logic       clk;
    logic       clr_n;
    logic       ld0, ld1;
    logic [7:0] din0, din1;
    logic       sout0, busy0, done0;
    logic       sout1, busy1, done1;

    int total;
    int bad;

    serial_tx #(.WIDTH(8), .CLK_DIV(4)) u_div4 (
        .clk(clk), .clr_n(clr_n), .ld(ld0), .din(din0),
        .sout(sout0), .busy(busy0), .done(done0)
    );

    serial_tx #(.WIDTH(8), .CLK_DIV(1)) u_div1 (
        .clk(clk), .clr_n(clr_n), .ld(ld1), .din(din1),
        .sout(sout1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Line level expected k cycles after the accepting edge (k=0 is the
    // first start-bit cycle).
    function automatic logic exp_line(input logic [7:0] data, input int k,
                                      input int div);
        int b;
        b = k / div;
        if (b == 0)      return 1'b0;
        else if (b <= 8) return data[b-1];
        else             return 1'b1;
    endfunction

    function automatic int div_of(input int sel);
        return (sel != 0) ? 1 : 4;
    endfunction

    task automatic set_in(input int sel, input logic l, input logic [7:0] d);
        if (sel != 0) begin ld1 = l; din1 = d; end
        else          begin ld0 = l; din0 = d; end
    endtask

    task automatic get_out(input int sel, output logic s, output logic b,
                           output logic d);
        if (sel != 0) begin s = sout1; b = busy1; d = done1; end
        else          begin s = sout0; b = busy0; d = done0; end
    endtask

    // Called at a negedge: present ld/din and let the next posedge accept.
    task automatic accept(input int sel, input logic [7:0] data);
        set_in(sel, 1'b1, data);
        @(posedge clk);
    endtask

    // Checks every cycle of a frame plus the done cycle, sampled on negedges.
    //  hold    : keep ld high; at the done cycle present next_d for a
    //            back-to-back frame
    //  ign_k   : cycle at which to pulse ld with din=0 (-1 = never)
    //  toggle  : invert din every cycle of the frame
    task automatic check_frame(input string name, input int sel,
                               input logic [7:0] data, input bit hold,
                               input logic [7:0] next_d, input int ign_k,
                               input bit toggle);
        int   n;
        logic s, b, d;
        logic [7:0] cur;
        n   = 10 * div_of(sel);
        cur = data;
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            get_out(sel, s, b, d);
            if (k < n) begin
                chk($sformatf("%s.sout[%0d]", name, k), s,
                    exp_line(data, k, div_of(sel)));
                if ((k % div_of(sel)) == 0 || k == n - 1) begin
                    chk($sformatf("%s.busy[%0d]", name, k), b, 1'b1);
                    chk($sformatf("%s.done[%0d]", name, k), d, 1'b0);
                end
            end else begin
                chk($sformatf("%s.idle_sout", name), s, 1'b1);
                chk($sformatf("%s.idle_busy", name), b, 1'b0);
                chk($sformatf("%s.done", name), d, 1'b1);
            end
            if (toggle) cur = ~cur;
            if (k == n && hold)  set_in(sel, 1'b1, next_d);
            else if (k == ign_k) set_in(sel, 1'b1, 8'h00);
            else if (hold)       set_in(sel, 1'b1, cur);
            else                 set_in(sel, 1'b0, cur);
        end
    endtask

    task automatic check_idle(input string name, input int sel, input int cycles);
        logic s, b, d;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            get_out(sel, s, b, d);
            chk($sformatf("%s.sout[%0d]", name, k), s, 1'b1);
            chk($sformatf("%s.busy[%0d]", name, k), b, 1'b0);
            chk($sformatf("%s.done[%0d]", name, k), d, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] r;
        total = 0;
        bad   = 0;
        ld0 = 1'b0; din0 = 8'h00;
        ld1 = 1'b0; din1 = 8'h00;
        clr_n = 1'b1;
        #1 clr_n = 1'b0;
        #1;
        chk("rst.sout0", sout0, 1'b1);
        chk("rst.busy0", busy0, 1'b0);
        chk("rst.done0", done0, 1'b0);
        chk("rst.sout1", sout1, 1'b1);
        chk("rst.busy1", busy1, 1'b0);
        repeat (3) @(negedge clk);
        clr_n = 1'b1;
        check_idle("post_rst", 0, 3);

        // Single frame, A5 at CLK_DIV=4.
        accept(0, 8'hA5);
        check_frame("a5", 0, 8'hA5, 1'b0, 8'h00, -1, 1'b0);
        check_idle("a5_after", 0, 5);

        // Request while busy must be ignored.
        accept(0, 8'hFF);
        check_frame("ign", 0, 8'hFF, 1'b0, 8'h00, 9, 1'b0);
        check_idle("ign_after", 0, 12);

        // ld held high: back-to-back frames with one idle cycle.
        accept(0, 8'h3C);
        check_frame("b2b_1", 0, 8'h3C, 1'b1, 8'hC3, -1, 1'b0);
        @(posedge clk);
        check_frame("b2b_2", 0, 8'hC3, 1'b0, 8'h00, -1, 1'b0);
        check_idle("b2b_after", 0, 6);

        // CLK_DIV=1 boundary.
        accept(1, 8'h01);
        check_frame("div1", 1, 8'h01, 1'b0, 8'h00, -1, 1'b0);
        check_idle("div1_after", 1, 3);

        // din toggling during the frame.
        accept(0, 8'h5A);
        check_frame("stab", 0, 8'h5A, 1'b0, 8'h00, -1, 1'b1);
        check_idle("stab_after", 0, 3);

        // Random frames on both instances.
        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom);
            accept(0, r);
            check_frame($sformatf("rnd4_%0d", i), 0, r, 1'b0, 8'h00, -1, 1'b0);
            r = 8'($urandom);
            accept(1, r);
            check_frame($sformatf("rnd1_%0d", i), 1, r, 1'b0, 8'h00, -1, 1'b0);
        end

        // Reset mid-frame, asserted between clock edges.
        accept(0, 8'($urandom));
        set_in(0, 1'b0, 8'h00);
        repeat (12) @(negedge clk);
        #2 clr_n = 1'b0;
        #1;
        chk("midrst.sout", sout0, 1'b1);
        chk("midrst.busy", busy0, 1'b0);
        chk("midrst.done", done0, 1'b0);
        @(negedge clk);
        clr_n = 1'b1;
        check_idle("midrst_after", 0, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
